// File: rtl/gtech_rr_arb4.sv
// Four-requester round-robin arbiter with registered one-hot grant, optional hold
// timeout and a mandatory one-cycle dead gap between successive owners.
module gtech_rr_arb4 #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       CP,
   input  logic       CD,
   input  logic [3:0] REQ,
   output logic [3:0] GNT,
   output logic [1:0] GNT_ID,
   output logic       BUSY,
   output logic       ANY_REQ,
   output logic       TIMEOUT
);

   typedef enum logic [1:0] {ARB, OWN, GAP} state_t;

   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
   localparam bit         HOLD_EN  = (MAX_HOLD != 0);

   state_t     r_state,   w_stateNext;
   logic [3:0] r_gnt,     w_gntNext;
   logic [1:0] r_gntId,   w_gntIdNext;
   logic [1:0] r_ptr,     w_ptrNext;
   logic [7:0] r_hcnt,    w_hcntNext;
   logic       r_busy,    w_busyNext;
   logic       r_timeout, w_timeoutNext;

   logic [1:0] w_winner;
   logic [1:0] w_idx;
   logic       w_found;

   assign ANY_REQ = |REQ;

   // Rotating priority scan: PTR first, then PTR+1.. wrapping modulo 4.
   always_comb begin
      w_winner = '0;
      w_found  = 1'b0;
      w_idx    = '0;
      for (int k = 0; k < 4; k++) begin
         w_idx = r_ptr + 2'(k);
         if (!w_found && REQ[w_idx]) begin
            w_winner = w_idx;
            w_found  = 1'b1;
         end
      end
   end

   always_comb begin
      w_stateNext   = r_state;
      w_gntNext     = r_gnt;
      w_gntIdNext   = r_gntId;
      w_ptrNext     = r_ptr;
      w_hcntNext    = r_hcnt;
      w_busyNext    = r_busy;
      w_timeoutNext = 1'b0;
      case (r_state)
         ARB, GAP: begin
            w_gntNext   = 4'b0000;
            w_busyNext  = 1'b0;
            w_stateNext = ARB;
            if (w_found) begin
               w_gntNext   = 4'b0001 << w_winner;
               w_gntIdNext = w_winner;
               w_busyNext  = 1'b1;
               w_hcntNext  = 8'd1;
               w_stateNext = OWN;
            end
         end
         OWN: begin
            if (!REQ[r_gntId]) begin
               w_gntNext   = 4'b0000;
               w_busyNext  = 1'b0;
               w_ptrNext   = r_gntId + 2'd1;
               w_stateNext = GAP;
            end else if (HOLD_EN && (r_hcnt == HOLD_LIM)) begin
               w_gntNext     = 4'b0000;
               w_busyNext    = 1'b0;
               w_timeoutNext = 1'b1;
               w_ptrNext     = r_gntId + 2'd1;
               w_stateNext   = GAP;
            end else if (r_hcnt != 8'hFF) begin
               w_hcntNext = r_hcnt + 8'd1;
            end
         end
         default: begin
            w_gntNext   = 4'b0000;
            w_busyNext  = 1'b0;
            w_stateNext = ARB;
         end
      endcase
   end

   always_ff @(posedge CP or negedge CD) begin
      if (!CD) begin
         r_state   <= ARB;
         r_gnt     <= '0;
         r_gntId   <= '0;
         r_ptr     <= '0;
         r_hcnt    <= '0;
         r_busy    <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_gnt     <= w_gntNext;
         r_gntId   <= w_gntIdNext;
         r_ptr     <= w_ptrNext;
         r_hcnt    <= w_hcntNext;
         r_busy    <= w_busyNext;
         r_timeout <= w_timeoutNext;
      end
   end

   assign GNT     = r_gnt;
   assign GNT_ID  = r_gntId;
   assign BUSY    = r_busy;
   assign TIMEOUT = r_timeout;

endmodule

// File: doc/gtech_rr_arb4.md
Name: gtech_rr_arb4

Overview:
- Four-requester round-robin arbiter that shares a single resource, such as a bus or a shared OR/reduction datapath, among four clients.
- Registered one-hot grant; one grant at a time, held until the owner releases or a hold limit expires.
- Exports the combined request flag (OR of all four requests) for use by downstream gating logic.
- Sits between GTECH-level client blocks and the shared resource's enable/select.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles a grant may be held; legal range 0..255; 0 disables the timeout.

Ports:
- CP  input  1  clock, rising-edge active.
- CD  input  1  asynchronous active-low reset (clear).
- REQ  input  4  level request per client; a client holds REQ[i] high for the whole time it uses the resource.
- GNT  output  4  registered one-hot grant; all zeros when there is no owner.
- GNT_ID  output  2  index of the current or last owner; valid while BUSY=1.
- BUSY  output  1  registered; equals the OR of GNT.
- ANY_REQ  output  1  combinational OR of REQ[3:0]; no latency.
- TIMEOUT  output  1  one-cycle pulse when a grant is forcibly revoked.

Behaviour:
- Reset (CD=0, asynchronous, takes effect immediately, including mid-grant):
  - GNT=0, GNT_ID=0, BUSY=0, TIMEOUT=0.
  - Priority pointer PTR=0, hold counter HCNT=0, state=ARB.
  - Operation resumes on the first CP edge after CD rises.
- Internal state: 2-bit PTR (highest-priority index), 8-bit HCNT, FSM {ARB, OWN, GAP}.
- Arbitration function: the winner is the first i with REQ[i]=1, scanning PTR, PTR+1, PTR+2, PTR+3, all modulo 4.
- ARB:
  - No REQ bit set: stay in ARB, GNT=0.
  - Any REQ bit set: at the next edge GNT[winner]=1, GNT_ID=winner, BUSY=1, HCNT=1, go to OWN.
  - Latency: REQ sampled high at edge k gives GNT high after edge k.
- OWN (owner w = GNT_ID):
  - REQ[w]=0 at an edge: GNT=0, BUSY=0, PTR=w+1 mod 4, go to GAP.
  - Else, MAX_HOLD!=0 and HCNT==MAX_HOLD: GNT=0, BUSY=0, TIMEOUT=1 for that cycle only, PTR=w+1 mod 4, go to GAP.
  - Else: HCNT increments, saturating at 255; grant is unchanged.
  - REQ changes on non-owner lines have no effect while in OWN.
- GAP:
  - Exactly one cycle with GNT=0, a guaranteed dead cycle between owners.
  - At the end of GAP, arbitration runs as in ARB using the updated PTR. A winner goes to OWN; no request goes to ARB.
  - Release to next grant therefore costs 2 edges: release seen, then GAP edge.
- Fairness:
  - The last owner always gets the lowest priority next round.
  - A timed-out client still holding REQ stays eligible, but at lowest priority.
  - With all four requesting continuously, grants rotate 0,1,2,3,0...
- Width rules:
  - HCNT counts cycles with GNT high. With MAX_HOLD=N, GNT is high for exactly N cycles on timeout.
  - MAX_HOLD=1 gives single-cycle grants.
- Invariants:
  - GNT is always one-hot or zero.
  - BUSY==|GNT.
  - TIMEOUT is never high for two consecutive cycles.
  - GNT_ID holds its value when BUSY=0.

Test Plan:
- Reset then single request: CD low, then REQ=4'b0100 at edge 1 → GNT=4'b0100, GNT_ID=2 after edge 1; REQ drops at edge 5 → GNT=0 after edge 5, PTR=3.
- All requesting, MAX_HOLD=16, each owner releases after 3 cycles then re-requests → grant order 0,1,2,3,0 with exactly one GNT=0 cycle between owners.
- Timeout: MAX_HOLD=4, REQ=4'b0011 held high → GNT=4'b0001 for 4 cycles, TIMEOUT pulse, 1 GAP cycle, GNT=4'b0010 for 4 cycles, TIMEOUT, then back to 0.
- Timeout disabled: MAX_HOLD=0, REQ[3] held for 300 cycles → GNT=4'b1000 throughout, TIMEOUT never asserted, HCNT saturates at 255.
- Async reset mid-grant: GNT=4'b0010, CD pulled low between edges → GNT=0 and BUSY=0 immediately without a clock; after release, REQ=4'b1111 → GNT=4'b0001 (PTR back to 0).
- ANY_REQ and non-owner churn: owner 1 active while REQ[3] toggles every cycle → GNT is unchanged, and ANY_REQ tracks the OR of REQ combinationally in the same cycle.
